led_trail_pwm: RTL and testbench

//   Downstream consumer of the 8-bit bouncing one-hot LED pattern. Turns each

---
 rtl/led_trail_pwm_pkg.sv | 32 +++
 rtl/led_trail_pwm_channel.sv | 32 +++
 rtl/led_trail_pwm.sv | 64 ++++++
 tb/tb_led_trail_pwm.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/led_trail_pwm_pkg.sv
// Shared constants and helpers for the LED comet-trail PWM renderer.
package led_trail_pwm_pkg;

   localparam int WIDTH_D    = 8;
   localparam int PWM_BITS_D = 4;
   localparam int DECAY_D    = 4;

   function automatic int max_of(input int bits);
      return (1 << bits) - 1;
   endfunction

   function automatic int sat_sub(input int a, input int d);
      return (a > d) ? a - d : 0;
   endfunction

   function automatic int popcount(input logic [31:0] v);
      int n;
      n = 0;
      for (int i = 0; i < 32; i++)
         n += int'(v[i]);
      return n;
   endfunction

   function automatic int hsb(input logic [31:0] v);
      int h;
      h = 0;
      for (int i = 0; i < 32; i++)
         if (v[i]) h = i;
      return h;
   endfunction

endpackage

// File: rtl/led_trail_pwm_channel.sv
// One LED: brightness register with set/decay, PWM compare, registered drive.
module led_pwm_channel
   import led_trail_pwm_pkg::*;
#(
   parameter int PWM_BITS = PWM_BITS_D,
   parameter int DECAY    = DECAY_D
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                step,
   input  logic                set,
   input  logic [PWM_BITS-1:0] pwm_cnt,
   output logic                led
);

   localparam int MAX = max_of(PWM_BITS);

   logic [PWM_BITS-1:0] bright;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bright <= '0;
         led    <= 1'b0;
      end else begin
         if (step)
            bright <= set ? PWM_BITS'(MAX)
                          : PWM_BITS'(sat_sub(int'(bright), DECAY));
         led <= (bright > pwm_cnt);
      end
   end

endmodule

// File: rtl/led_trail_pwm.sv
// Comet-trail renderer for the bouncing one-hot LED pattern.
module led_trail_pwm
   import led_trail_pwm_pkg::*;
#(
   parameter int WIDTH    = WIDTH_D,
   parameter int PWM_BITS = PWM_BITS_D,
   parameter int DECAY    = DECAY_D
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] pattern,
   input  logic             pat_valid,
   input  logic             clr_err,
   output logic [WIDTH-1:0] led,
   output logic [2:0]       pos,
   output logic             onehot_err
);

   localparam int MAX = max_of(PWM_BITS);

   logic [PWM_BITS-1:0] pwm_cnt;
   logic                bad;

   assign bad = (popcount(32'(pattern)) != 1);

   // Period is MAX cycles so bright==MAX never drops out.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         pwm_cnt <= '0;
      else if (pwm_cnt == PWM_BITS'(MAX - 1))
         pwm_cnt <= '0;
      else
         pwm_cnt <= pwm_cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pos        <= '0;
         onehot_err <= 1'b0;
      end else begin
         if (pat_valid && |pattern)
            pos <= 3'(hsb(32'(pattern)));
         if (pat_valid && bad)
            onehot_err <= 1'b1;
         else if (clr_err)
            onehot_err <= 1'b0;
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      led_pwm_channel #(
         .PWM_BITS(PWM_BITS),
         .DECAY   (DECAY)
      ) u_ch (
         .clk    (clk),
         .reset  (reset),
         .step   (pat_valid),
         .set    (pattern[i]),
         .pwm_cnt(pwm_cnt),
         .led    (led[i])
      );
   end

endmodule

// File: tb/tb_led_trail_pwm.sv
// Scoreboard bench for led_trail_pwm against a brightness/duty model.
module tb_led_trail_pwm;

   localparam int MAX   = 15;
   localparam int DECAY = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] pattern = '0;
   logic       pat_valid = 1'b0;
   logic       clr_err = 1'b0;
   logic [7:0] led;
   logic [2:0] pos;
   logic       onehot_err;

   led_trail_pwm dut (
      .clk       (clk),
      .reset     (reset),
      .pattern   (pattern),
      .pat_valid (pat_valid),
      .clr_err   (clr_err),
      .led       (led),
      .pos       (pos),
      .onehot_err(onehot_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] led;
      logic [2:0] pos;
      logic       err;
   } exp_t;

   exp_t q[$];
   int   bright[8];
   int   k;
   int   mpos;
   bit   merr;
   int   npass = 0;
   int   ntotal = 0;

   task automatic chk(input string n, input int a, input int x);
      ntotal++;
      if (a == x) npass++;
      else $display("FAIL %s: got %0d expected %0d", n, a, x);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) bright[i] = 0;
      k = 0;
      mpos = 0;
      merr = 1'b0;
   endtask

   // One clock step; expected outputs after the edge go to the scoreboard.
   task automatic cyc(input logic [7:0] p, input logic v, input logic c);
      exp_t e;
      int   cnt;
      pattern = p;
      pat_valid = v;
      clr_err = c;
      @(posedge clk);
      for (int i = 0; i < 8; i++)
         e.led[i] = (bright[i] > (k % MAX));
      cnt = 0;
      if (v) begin
         for (int i = 0; i < 8; i++) begin
            if (p[i]) begin
               bright[i] = MAX;
               mpos = i;
               cnt++;
            end else begin
               bright[i] = (bright[i] > DECAY) ? bright[i] - DECAY : 0;
            end
         end
      end
      if (v && cnt != 1) merr = 1'b1;
      else if (c) merr = 1'b0;
      e.pos = 3'(mpos);
      e.err = merr;
      q.push_back(e);
      k++;
      #1;
   endtask

   always @(negedge clk) begin
      if (reset && q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("led", int'(led), int'(e.led));
         chk("pos", int'(pos), int'(e.pos));
         chk("onehot_err", int'(onehot_err), int'(e.err));
      end
   end

   initial begin
      int h0, h1, hx;
      logic [7:0] acc;
      logic [7:0] p;
      int n;

      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_led", int'(led), 0);
      chk("rst_pos", int'(pos), 0);
      chk("rst_err", int'(onehot_err), 0);
      #1 reset = 1'b1;

      repeat (3) cyc(8'h00, 1'b0, 1'b0);

      cyc(8'h01, 1'b1, 1'b0);
      cyc(8'h02, 1'b1, 1'b0);
      h0 = 0; h1 = 0; hx = 0;
      for (int c = 0; c < MAX; c++) begin
         cyc(8'h00, 1'b0, 1'b0);
         h0 += int'(led[0]);
         h1 += int'(led[1]);
         hx += $countones(led[7:2]);
      end
      chk("duty_led0", h0, 11);
      chk("duty_led1", h1, 15);
      chk("duty_other", hx, 0);
      chk("pos_after_02", int'(pos), 1);

      repeat (5) begin
         cyc(8'h02, 1'b1, 1'b0);
         cyc(8'h00, 1'b0, 1'b0);
      end
      repeat (MAX) cyc(8'h00, 1'b0, 1'b0);

      cyc(8'h03, 1'b1, 1'b0);
      cyc(8'h00, 1'b1, 1'b1);
      chk("set_wins", int'(onehot_err), 1);
      chk("pos_hold_zero", int'(pos), 1);
      cyc(8'h00, 1'b0, 1'b1);
      chk("clr_err", int'(onehot_err), 0);

      cyc(8'h80, 1'b1, 1'b0);
      repeat (4) cyc(8'h00, 1'b0, 1'b0);
      cyc(8'h03, 1'b1, 1'b0);
      cyc(8'h00, 1'b0, 1'b0);
      @(negedge clk);
      #1 reset = 1'b0;
      #1;
      chk("async_led", int'(led), 0);
      chk("async_pos", int'(pos), 0);
      chk("async_err", int'(onehot_err), 0);
      model_reset();
      @(negedge clk);
      #1 reset = 1'b1;

      for (int s = 0; s < 15; s++) begin
         n = (s < 8) ? s : 14 - s;
         p = 8'(1 << n);
         acc = '0;
         cyc(p, 1'b1, 1'b0);
         acc |= led;
         repeat (15) begin
            cyc(8'h00, 1'b0, 1'b0);
            acc |= led;
         end
         chk("bounce_pos", int'(pos), n);
         chk("trail_le4", int'($countones(acc) <= 4), 1);
      end

      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(0, 9) < 7) p = 8'(1 << $urandom_range(0, 7));
         else p = 8'($urandom);
         cyc(p, ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
      end

      repeat (3) @(negedge clk);
      chk("drain", q.size(), 0);
      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
